dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (256 x 32 RAM) between two requesters: the CPU load/store path (port C)
//  and a debug/program loader (port L) that fills or dumps memory while the core runs or is held.
//  Sits between the processor datapath and the RAM. CPU has fixed priority; a starvation counter guarantees
//  loader progress, and the CPU is stalled whenever it requests but is not granted.
// PARAMETERS
//  ADDR_W        8    word-address width (RAM depth = 2**ADDR_W)
//  DATA_W        32   data width
//  STARVE_LIMIT  4    max consecutive cycles a requesting loader may be refused before it wins (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  c_req        in   1       CPU access request (held until granted)
//  c_we         in   1       CPU access is write (1) / read (0)
//  c_addr       in   ADDR_W  CPU word address
//  c_wdata      in   DATA_W  CPU write data
//  c_gnt        out  1       CPU access performed this cycle
//  c_stall      out  1       c_req & ~c_gnt; freezes PC/pipeline
//  c_rvalid     out  1       CPU read data valid (one cycle after read grant)
//  c_rdata      out  DATA_W  CPU read data
//  l_req/l_we   in   1       loader request / write
//  l_addr       in   ADDR_W  loader word address
//  l_wdata      in   DATA_W  loader write data
//  l_lock       in   1       loader keeps grant on following cycles while l_req stays high
//  l_gnt        out  1       loader access performed this cycle
//  l_rvalid     out  1       loader read data valid
//  l_rdata      out  DATA_W  loader read data
//  mem_addr     out  ADDR_W  RAM address;  mem_wdata out DATA_W RAM write data
//  mem_we       out  1       RAM write enable (write at clock edge of grant cycle)
//  mem_re       out  1       RAM read enable;  mem_rdata in DATA_W RAM data, valid 1 cycle after mem_re
// BEHAVIOUR
//  - Reset: all gnt, rvalid, mem_we, mem_re = 0; rdata = 0; starve_cnt = 0; owner = NONE; pending read cleared.
//    A read granted in the cycle reset is asserted produces no rvalid.
//  - Grant is combinational in the request cycle; at most one of c_gnt/l_gnt high; mem_* driven from winner,
//    mem_we = winner.we, mem_re = ~winner.we; with no grant mem_we = mem_re = 0, mem_addr/wdata = 0.
//  - Winner selection, in priority order:
//     1. owner == LOADER (lock held) and l_req -> loader.
//     2. l_req and starve_cnt == STARVE_LIMIT -> loader.
//     3. c_req -> CPU.   4. l_req -> loader.
//  - starve_cnt: +1 each cycle l_req & ~l_gnt (saturates at STARVE_LIMIT); cleared on l_gnt or ~l_req.
//  - Lock FSM states NONE, LOADER: NONE->LOADER on l_gnt & l_lock; LOADER->NONE when ~l_req or ~l_lock.
//    While LOADER, c_stall stays high for as long as c_req is held.
//  - Read return: registered rd_port (C/L/none). Cycle after a read grant, that port's rvalid=1 and its
//    rdata = mem_rdata; rdata holds last value otherwise. Back-to-back reads allowed (one per cycle, in order).
//  - Writes give no rvalid. Simultaneous c_req & l_req with starve_cnt < STARVE_LIMIT: CPU wins, loader waits.
//  - Address wrap: addresses are taken modulo 2**ADDR_W; no out-of-range error.
// STRUCTURE
//  - Package dmem_arb_pkg: owner encoding (OWN_NONE, OWN_LOADER), rd_port encoding (RD_NONE, RD_CPU, RD_LDR).
//  - One sub-module: arb_starve_counter (saturating counter, inc/clr inputs, at_limit output).
//  - Top holds lock FSM, winner mux, read-return register.
// TESTING
//  1. reset high 2 cycles with c_req=l_req=1 -> all gnt/rvalid=0, mem_we=mem_re=0; after release CPU granted first.
//  2. CPU write addr 0x10 data 0xDEADBEEF, next cycle CPU read 0x10 -> c_rvalid one cycle later, c_rdata=0xDEADBEEF.
//  3. c_req and l_req held continuously, STARVE_LIMIT=4 -> pattern C,C,C,C,L repeating; c_stall high in L cycle.
//  4. l_lock=1, l_req for 6 cycles, c_req raised in cycle 2 -> l_gnt all 6 cycles, c_gnt on cycle 7.
//  5. Loader reads 0xFF then 0x00 back-to-back -> l_rvalid 2 consecutive cycles, data in order; c_rvalid stays 0.
//  6. Reset asserted the cycle after a CPU read grant -> no c_rvalid; starve_cnt and lock state cleared.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: lock owner and pending read-return port.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_NONE,
        OWN_LOADER
    } owner_e;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CPU,
        RD_LDR
    } rd_port_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the loader has been refused; at_limit forces a loader win.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU (fixed priority) and the debug loader,
// with a loader lock and a starvation guarantee; read data returns one cycle after the grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e   owner_q, owner_d;
    rd_port_e rdPort_q, rdPort_d;
    logic [DATA_W-1:0] cRdata_q;
    logic [DATA_W-1:0] lRdata_q;
    logic starveHit;

    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc     (l_req & ~l_gnt),
        .clr     (l_gnt | ~l_req),
        .at_limit(starveHit)
    );

    // Loader wins on held lock, on starvation, or when the CPU is idle; nothing is granted in reset.
    always_comb begin
        l_gnt = l_req && !reset &&
                ((owner_q == OWN_LOADER) || starveHit || !c_req);
        c_gnt = c_req && !reset && !l_gnt;
        c_stall = c_req && !c_gnt;

        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        rdPort_d  = RD_NONE;
        if (c_gnt) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_we    = c_we;
            mem_re    = !c_we;
            rdPort_d  = c_we ? RD_NONE : RD_CPU;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
            mem_we    = l_we;
            mem_re    = !l_we;
            rdPort_d  = l_we ? RD_NONE : RD_LDR;
        end

        owner_d = owner_q;
        case (owner_q)
            OWN_NONE:   if (l_gnt && l_lock) owner_d = OWN_LOADER;
            OWN_LOADER: if (!l_req || !l_lock) owner_d = OWN_NONE;
            default:    owner_d = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            rdPort_q <= RD_NONE;
            cRdata_q <= '0;
            lRdata_q <= '0;
        end else begin
            owner_q  <= owner_d;
            rdPort_q <= rdPort_d;
            if (c_rvalid) cRdata_q <= mem_rdata;
            if (l_rvalid) lRdata_q <= mem_rdata;
        end
    end

    // A pending return is squashed if reset arrives in the return cycle.
    assign c_rvalid = (rdPort_q == RD_CPU) && !reset;
    assign l_rvalid = (rdPort_q == RD_LDR) && !reset;
    assign c_rdata  = c_rvalid ? mem_rdata : cRdata_q;
    assign l_rdata  = l_rvalid ? mem_rdata : lRdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant checks plus a read-data scoreboard fed by a RAM model.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cReq, cWe, lReq, lWe, lLock;
    logic [7:0]  cAddr, lAddr;
    logic [31:0] cWdata, lWdata;
    logic        cGnt, cStall, cRvalid, lGnt, lRvalid;
    logic [31:0] cRdata, lRdata;
    logic [7:0]  memAddr;
    logic [31:0] memWdata, memRdata;
    logic        memWe, memRe;

    int assertCount = 0;
    int failCount   = 0;
    logic [31:0] cExpQ[$];
    logic [31:0] lExpQ[$];
    logic [31:0] ram [256];

    dmem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .c_req    (cReq),
        .c_we     (cWe),
        .c_addr   (cAddr),
        .c_wdata  (cWdata),
        .c_gnt    (cGnt),
        .c_stall  (cStall),
        .c_rvalid (cRvalid),
        .c_rdata  (cRdata),
        .l_req    (lReq),
        .l_we     (lWe),
        .l_addr   (lAddr),
        .l_wdata  (lWdata),
        .l_lock   (lLock),
        .l_gnt    (lGnt),
        .l_rvalid (lRvalid),
        .l_rdata  (lRdata),
        .mem_addr (memAddr),
        .mem_wdata(memWdata),
        .mem_we   (memWe),
        .mem_re   (memRe),
        .mem_rdata(memRdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM: write at the grant edge, read data one cycle after mem_re.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (memWe) ram[memAddr] <= memWdata;
        if (memRe) memRdata <= ram[memAddr];
    end

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read return must match the oldest expected value for that port.
    always @(negedge clk) begin
        if (cRvalid === 1'b1) begin
            if (cExpQ.size() == 0) begin
                check1("c_rvalid_unexpected", 32'(cRvalid), 32'h0);
            end else begin
                check1("c_rdata", cRdata, cExpQ.pop_front());
            end
        end
        if (lRvalid === 1'b1) begin
            if (lExpQ.size() == 0) begin
                check1("l_rvalid_unexpected", 32'(lRvalid), 32'h0);
            end else begin
                check1("l_rdata", lRdata, lExpQ.pop_front());
            end
        end
    end

    task automatic checkOutput(input logic creq, input logic cwe, input logic [7:0] caddr,
                               input logic lwe, input logic [7:0] laddr,
                               input logic expC, input logic expL);
        logic expWe, expRe;
        logic [7:0] expAddr;
        expWe   = expC ? cwe  : (expL ? lwe  : 1'b0);
        expRe   = expC ? !cwe : (expL ? !lwe : 1'b0);
        expAddr = expC ? caddr : (expL ? laddr : 8'h0);
        check1("c_gnt",   32'(cGnt),   32'(expC));
        check1("l_gnt",   32'(lGnt),   32'(expL));
        check1("c_stall", 32'(cStall), 32'(creq && !expC));
        check1("mem_we",  32'(memWe),  32'(expWe));
        check1("mem_re",  32'(memRe),  32'(expRe));
        check1("mem_addr", 32'(memAddr), 32'(expAddr));
    endtask

    task automatic applyStimulus(input logic rst,
                                 input logic creq, input logic cwe, input logic [7:0] caddr,
                                 input logic [31:0] cwd,
                                 input logic lreq, input logic lwe, input logic [7:0] laddr,
                                 input logic [31:0] lwd, input logic llock,
                                 input logic expC, input logic expL,
                                 input logic pushRd, input logic [31:0] expRd);
        @(posedge clk);
        #1;
        reset = rst;
        cReq = creq; cWe = cwe; cAddr = caddr; cWdata = cwd;
        lReq = lreq; lWe = lwe; lAddr = laddr; lWdata = lwd; lLock = llock;
        if (pushRd && expC && !cwe) cExpQ.push_back(expRd);
        if (pushRd && expL && !lwe) lExpQ.push_back(expRd);
        #2;
        checkOutput(creq, cwe, caddr, lwe, laddr, expC, expL);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 8'h0, 0, 0, 0, 8'h0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        cReq = 0; cWe = 0; cAddr = 0; cWdata = 0;
        lReq = 0; lWe = 0; lAddr = 0; lWdata = 0; lLock = 0;

        $display("[TB] reset with both requests pending");
        applyStimulus(1, 1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 0, 0, 0, 1, 32'h0);
        applyStimulus(1, 1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 0, 0, 0, 1, 32'h0);

        $display("[TB] CPU write then read-back, loader waiting");
        applyStimulus(0, 1, 1, 8'h10, 32'hDEADBEEF, 1, 1, 8'h11, 32'h11111111, 0, 1, 0, 1, 0);
        check1("c_rdata_after_reset", cRdata, 32'h0);
        check1("l_rdata_after_reset", lRdata, 32'h0);
        applyStimulus(0, 1, 0, 8'h10, 0, 1, 1, 8'h11, 32'h11111111, 0, 1, 0, 1, 32'hDEADBEEF);
        idle(2);

        $display("[TB] contention: four CPU wins then one loader win");
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 1, 1, 8'(8'h20 + i), 32'(i), 1, 1, 8'(8'h30 + i), 32'(i + 100), 0,
                          (i % 5) != 4, (i % 5) == 4, 0, 0);
        idle(1);

        $display("[TB] locked loader burst");
        for (int i = 0; i < 6; i++)
            applyStimulus(0, i >= 1, 0, 8'h10, 0, 1, 1, 8'(8'h40 + i), 32'(i + 200), 1,
                          0, 1, 1, 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 8'h10, 0, 0, 0, 8'h0, 0, 0, 1, 0, 1, 32'hDEADBEEF);
        idle(1);

        $display("[TB] loader back-to-back reads");
        applyStimulus(0, 0, 0, 8'h0, 0, 1, 1, 8'hFF, 32'hA5A50FF0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 8'h0, 0, 1, 1, 8'h00, 32'h12345678, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 8'h0, 0, 1, 0, 8'hFF, 0, 0, 0, 1, 1, 32'hA5A50FF0);
        applyStimulus(0, 0, 0, 8'h0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 1, 32'h12345678);
        idle(2);

        $display("[TB] reset squashes pending read and clears starvation");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 1, 8'(8'h50 + i), 0, 1, 1, 8'h60, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 8'h10, 0, 1, 1, 8'h60, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 8'h0, 0, 1, 1, 8'h60, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 1, 8'(8'h70 + i), 0, 1, 1, 8'h61, 0, 0, i != 4, i == 4, 0, 0);
        idle(1);

        $display("[TB] reset clears loader lock");
        applyStimulus(0, 0, 0, 8'h0, 0, 1, 1, 8'h62, 0, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 8'h0, 0, 1, 1, 8'h62, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 8'h78, 0, 1, 1, 8'h62, 0, 1, 1, 0, 0, 0);
        idle(3);

        check1("c_queue_drained", 32'(cExpQ.size()), 32'h0);
        check1("l_queue_drained", 32'(lExpQ.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
